// File: rtl/sc_sidecomparator_pkg.sv
// Shared types and constants for the side comparator: last-side state encoding and compare modes.
package sc_sidecomparator_pkg;

    typedef enum logic [1:0] {
        SIDE_NONE  = 2'b00,
        SIDE_LEFT  = 2'b01,
        SIDE_RIGHT = 2'b10
    } side_e;

    localparam logic MODE_EXACT   = 1'b0;
    localparam logic MODE_EDGEBIT = 1'b1;

endpackage

// File: rtl/sc_sidequalifier.sv
// Per-side persistence qualifier: a raw hit must hold for HOLDCYCLES enabled clocks
// before the level rises; the pulse marks the qualifying edge only.
module sc_sidequalifier #(
    parameter int unsigned HOLDCYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_clear,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse,
    output logic o_qualify
);

    localparam int unsigned CW = $clog2(HOLDCYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_pulse;
    logic          w_qualify;

    // High in the cycle whose edge brings the counter to HOLDCYCLES; lets the
    // parent update last-side state on the same edge the pulse rises.
    assign w_qualify = i_enable && !i_clear && i_raw && (r_cnt == CW'(HOLDCYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else if (i_clear) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else if (i_enable) begin
            if (i_raw) begin
                if (r_cnt != CW'(HOLDCYCLES)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_qualify) begin
                    r_level <= 1'b1;
                end
                r_pulse <= w_qualify;
            end else begin
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_pulse <= 1'b0;
            end
        end else begin
            r_pulse <= 1'b0;
        end
    end

    assign o_level   = r_level;
    assign o_pulse   = r_pulse;
    assign o_qualify = w_qualify;

endmodule

// File: rtl/sc_sidecomparator_dual.sv
// Boundary detector for the shifting-bit bus: qualifies left (MSB) / right (LSB) hits,
// tracks the last side hit and counts left/right bounces.
module sc_sidecomparator_dual
    import sc_sidecomparator_pkg::*;
#(
    parameter int unsigned DATAWIDTH  = 8,
    parameter int unsigned HOLDCYCLES = 2,
    parameter int unsigned COUNTWIDTH = 4
) (
    input  logic                  SC_SIDECOMPARATOR_CLOCK_50,
    input  logic                  SC_SIDECOMPARATOR_RESET_InLow,
    input  logic                  SC_SIDECOMPARATOR_enable_InHigh,
    input  logic                  SC_SIDECOMPARATOR_clear_InHigh,
    input  logic                  SC_SIDECOMPARATOR_mode_InHigh,
    input  logic [DATAWIDTH-1:0]  SC_SIDECOMPARATOR_data_InBUS,
    output logic                  SC_SIDECOMPARATOR_left_OutHigh,
    output logic                  SC_SIDECOMPARATOR_right_OutHigh,
    output logic                  SC_SIDECOMPARATOR_leftPulse_OutHigh,
    output logic                  SC_SIDECOMPARATOR_rightPulse_OutHigh,
    output logic [1:0]            SC_SIDECOMPARATOR_lastSide_OutBUS,
    output logic [COUNTWIDTH-1:0] SC_SIDECOMPARATOR_bounceCount_OutBUS
);

    localparam logic [DATAWIDTH-1:0] LEFT_ONEHOT  = {1'b1, {(DATAWIDTH-1){1'b0}}};
    localparam logic [DATAWIDTH-1:0] RIGHT_ONEHOT = {{(DATAWIDTH-1){1'b0}}, 1'b1};

    logic                  w_leftHit;
    logic                  w_rightHit;
    logic                  w_rawLeft;
    logic                  w_rawRight;
    logic                  w_qualLeft;
    logic                  w_qualRight;
    logic                  w_bounceInc;
    side_e                 r_state;
    side_e                 w_stateNext;
    logic [COUNTWIDTH-1:0] r_bounce;

    always_comb begin
        if (SC_SIDECOMPARATOR_mode_InHigh == MODE_EDGEBIT) begin
            w_leftHit  = SC_SIDECOMPARATOR_data_InBUS[DATAWIDTH-1];
            w_rightHit = SC_SIDECOMPARATOR_data_InBUS[0];
        end else begin
            w_leftHit  = (SC_SIDECOMPARATOR_data_InBUS == LEFT_ONEHOT);
            w_rightHit = (SC_SIDECOMPARATOR_data_InBUS == RIGHT_ONEHOT);
        end
    end

    // Simultaneous hits are ambiguous, so neither side is reported.
    assign w_rawLeft  = w_leftHit && !w_rightHit;
    assign w_rawRight = w_rightHit && !w_leftHit;

    sc_sidequalifier #(.HOLDCYCLES(HOLDCYCLES)) u_qual_left (
        .i_clk     (SC_SIDECOMPARATOR_CLOCK_50),
        .i_rst_n   (SC_SIDECOMPARATOR_RESET_InLow),
        .i_enable  (SC_SIDECOMPARATOR_enable_InHigh),
        .i_clear   (SC_SIDECOMPARATOR_clear_InHigh),
        .i_raw     (w_rawLeft),
        .o_level   (SC_SIDECOMPARATOR_left_OutHigh),
        .o_pulse   (SC_SIDECOMPARATOR_leftPulse_OutHigh),
        .o_qualify (w_qualLeft)
    );

    sc_sidequalifier #(.HOLDCYCLES(HOLDCYCLES)) u_qual_right (
        .i_clk     (SC_SIDECOMPARATOR_CLOCK_50),
        .i_rst_n   (SC_SIDECOMPARATOR_RESET_InLow),
        .i_enable  (SC_SIDECOMPARATOR_enable_InHigh),
        .i_clear   (SC_SIDECOMPARATOR_clear_InHigh),
        .i_raw     (w_rawRight),
        .o_level   (SC_SIDECOMPARATOR_right_OutHigh),
        .o_pulse   (SC_SIDECOMPARATOR_rightPulse_OutHigh),
        .o_qualify (w_qualRight)
    );

    always_comb begin
        w_stateNext = r_state;
        w_bounceInc = 1'b0;
        if (w_qualLeft) begin
            w_bounceInc = (r_state == SIDE_RIGHT);
            w_stateNext = SIDE_LEFT;
        end else if (w_qualRight) begin
            w_bounceInc = (r_state == SIDE_LEFT);
            w_stateNext = SIDE_RIGHT;
        end
    end

    always_ff @(posedge SC_SIDECOMPARATOR_CLOCK_50 or negedge SC_SIDECOMPARATOR_RESET_InLow) begin
        if (!SC_SIDECOMPARATOR_RESET_InLow) begin
            r_state  <= SIDE_NONE;
            r_bounce <= '0;
        end else if (SC_SIDECOMPARATOR_clear_InHigh) begin
            r_state  <= SIDE_NONE;
            r_bounce <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_bounceInc && (r_bounce != '1)) begin
                r_bounce <= r_bounce + 1'b1;
            end
        end
    end

    assign SC_SIDECOMPARATOR_lastSide_OutBUS    = r_state;
    assign SC_SIDECOMPARATOR_bounceCount_OutBUS = r_bounce;

endmodule

// File: doc/sc_sidecomparator_dual.md
# sc_sidecomparator_dual

Registered, parametrised boundary detector for the shifting-bit data bus of the game datapath. It watches both ends of a DATAWIDTH-bit bus, the left end being the MSB and the right end the LSB. A side hit is reported only after it has persisted for HOLDCYCLES clocks. The block also tracks which side was hit last and counts left/right bounces, and it sits between the shift register and the game control FSM.

## Interface
- DATAWIDTH, 8, bus width; legal range ≥ 2.
- HOLDCYCLES, 2, number of consecutive enabled cycles a raw hit must persist before it qualifies; legal range ≥ 1.
- COUNTWIDTH, 4, width of the bounce counter.

- SC_SIDECOMPARATOR_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- SC_SIDECOMPARATOR_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_SIDECOMPARATOR_enable_InHigh  in  1  qualification and state advance enable.
- SC_SIDECOMPARATOR_clear_InHigh  in  1  synchronous clear of all state.
- SC_SIDECOMPARATOR_mode_InHigh  in  1  compare mode:
  - 0 = exact one-hot match (left = 100…0, right = 0…001);
  - 1 = edge-bit match (left = MSB set, right = LSB set).
- SC_SIDECOMPARATOR_data_InBUS  in  DATAWIDTH  bus being monitored.
- SC_SIDECOMPARATOR_left_OutHigh  out  1  qualified left level.
- SC_SIDECOMPARATOR_right_OutHigh  out  1  qualified right level.
- SC_SIDECOMPARATOR_leftPulse_OutHigh  out  1  one-cycle pulse when left qualifies.
- SC_SIDECOMPARATOR_rightPulse_OutHigh  out  1  one-cycle pulse when right qualifies.
- SC_SIDECOMPARATOR_lastSide_OutBUS  out  2  last-side state: NONE=00, LEFT=01, RIGHT=10.
- SC_SIDECOMPARATOR_bounceCount_OutBUS  out  COUNTWIDTH  saturating count of side alternations.

## Operation
- **Raw compare** (combinational, per side, per mode).
  - If both raw sides are true in the same cycle (mode 1, e.g. 10000001), both are treated as false.
- **Per-side qualifier** (hold counter, width $clog2(HOLDCYCLES+1)).
  - Raw true and enabled: the counter increments and saturates at HOLDCYCLES.
  - Raw false and enabled: the counter clears to 0 and the level clears.
  - The level sets on the edge where the counter reaches HOLDCYCLES.
  - The pulse is high only on that same cycle.
- **Last-side FSM**, states NONE, LEFT, RIGHT.
  - A left pulse moves the FSM to LEFT; a right pulse moves it to RIGHT.
  - A pulse naming the current state causes no change.
- **Bounce counter**
  - Increments on LEFT→RIGHT and RIGHT→LEFT transitions only.
  - NONE→any does not increment.
  - Saturates at 2^COUNTWIDTH−1.
- **Enable low**
  - Qualifier counters, levels, FSM and bounce counter all hold.
  - Pulses are forced to 0.
- **Clear high**
  - On the next edge, all state returns to its reset value, regardless of enable.
  - Clear has priority over every other update.
- **Mode change mid-hold:** raw is re-evaluated each cycle; no extra reset is applied.

## Timing
- Reset values: all levels 0, all pulses 0, lastSide = NONE (00), bounceCount = 0.
  - Asynchronous assertion; removal takes effect at the next clock edge.
- Qualification latency: a raw hit present at edges 1..HOLDCYCLES raises the level and pulse after edge HOLDCYCLES.
  - Only enabled cycles count toward HOLDCYCLES.
- Release latency: the level falls on the first edge at which raw is false.
- lastSide and bounceCount update on the same edge that the pulse rises.
- Left and right can never qualify together; at most one pulse is high per cycle.
- Reset mid-hold discards the partial count.

## Structure
- Package sc_sidecomparator_pkg holds:
  - typedef enum for the last-side state (NONE/LEFT/RIGHT, 2 bits);
  - mode constants MODE_EXACT=0 and MODE_EDGEBIT=1.
- Sub-module sc_sidequalifier contains:
  - the hold counter, level register and pulse generator;
  - parameter HOLDCYCLES.
- sc_sidequalifier is instantiated twice, once for left and once for right.
- Raw compares and the FSM/bounce counter live in the top module.

## Test plan
Defaults used: DATAWIDTH=8, HOLDCYCLES=2, enable=1.
- Reset, then hold mode 0 with data 10000000 for 3 cycles:
  - left rises after the 2nd edge;
  - leftPulse is high for 1 cycle;
  - lastSide=01 and bounceCount=0.
- Left qualifies, then data 00000001 for 2 cycles, then 10000000 for 2 cycles:
  - rightPulse, then leftPulse;
  - lastSide goes 10, then 01;
  - bounceCount=2.
- Mode 0 with data 11000000: no hit. Mode 1 with the same data: left qualifies after 2 edges. Mode 1 with data 10000001: neither side qualifies.
- Data 10000000 for 1 cycle, 00000000 for 1 cycle, then 10000000 for 1 cycle: no pulse. Data 10000000 for 2 cycles with enable low in between: qualification completes after 2 enabled edges, and no pulse is issued while enable is low.
- Bounce counter saturation: force 20 alternations → bounceCount saturates at 15.
- Assert clear during LEFT: on the next edge all outputs are 0 and lastSide=00. Drop RESET_InLow mid-hold: outputs go to 0 immediately, with no clock required.
